// File: rtl/input_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// input_sequencer_pkg
// Shared types and helpers for the input channel sequencer.
//   seq_state_t  : sequencer FSM states
//   pix_count    : pixels per channel plane (rows * cols)
//   next_channel : next non-drained channel after cur, wrapping; returns cur
//                  itself when it is the only non-drained channel left
// ---------------------------------------------------------------------------
package input_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRIME,
    FILL,
    STREAM,
    WAIT_RELEASE,
    DONE
  } seq_state_t;

  // Upper bound on channel count supported by next_channel's search vector.
  localparam int MAX_CHANNELS = 16;

  function automatic int pix_count(input int rows, input int cols);
    return rows * cols;
  endfunction

  // Searching from the farthest offset down to the nearest lets the nearest
  // non-drained channel overwrite the result, so no "found" flag is needed.
  function automatic int next_channel(input int cur,
                                      input logic [MAX_CHANNELS-1:0] drained,
                                      input int n_channels);
    int idx;
    int result;
    result = cur;
    for (int k = MAX_CHANNELS; k >= 1; k--) begin
      if (k <= n_channels) begin
        idx = cur + k;
        if (idx >= n_channels) idx = idx - n_channels;
        if (!drained[idx[3:0]]) result = idx;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/input_channel_sequencer_pointer_bank.sv
// ---------------------------------------------------------------------------
// channel_pointer_bank
// Per-channel read pointers and loaded/drained flags, plus RAM read address
// generation for the active channel.
// Ports:
//   i_clock, i_reset   : clock, synchronous active-high reset
//   i_cur              : active channel
//   i_advance          : increment ptr of the active channel
//   i_setLoaded        : mark active channel as having a pending word
//   i_setDrained       : mark active channel as fully transferred
//   i_lookAhead        : address the word after ptr (a load happens now)
//   o_curLoaded        : loaded flag of the active channel
//   o_curAtEnd         : active channel ptr has reached PIX
//   o_drained          : drained flags of all channels
//   o_rdAddress        : RAM read address, clamped to the channel's last word
// ---------------------------------------------------------------------------
module channel_pointer_bank #(
  parameter int ADDR_WIDTH = 16,
  parameter int N_CHANNELS = 3,
  parameter int PIX        = 784,
  parameter int BASE_ADDR  = 0,
  parameter int PTR_W      = 10,
  parameter int CUR_W      = 2
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [CUR_W-1:0]      i_cur,
  input  logic                  i_advance,
  input  logic                  i_setLoaded,
  input  logic                  i_setDrained,
  input  logic                  i_lookAhead,
  output logic                  o_curLoaded,
  output logic                  o_curAtEnd,
  output logic [N_CHANNELS-1:0] o_drained,
  output logic [ADDR_WIDTH-1:0] o_rdAddress
);

  logic [PTR_W-1:0]      r_ptr [N_CHANNELS];
  logic [N_CHANNELS-1:0] r_loaded;
  logic [N_CHANNELS-1:0] r_drained;
  int                    w_offset;
  int                    w_address;

  // Pointer and flag registers; only the active channel ever changes.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      for (int c = 0; c < N_CHANNELS; c++) r_ptr[c] <= '0;
      r_loaded  <= '0;
      r_drained <= '0;
    end else begin
      if (i_advance)    r_ptr[i_cur]     <= r_ptr[i_cur] + PTR_W'(1);
      if (i_setLoaded)  r_loaded[i_cur]  <= 1'b1;
      if (i_setDrained) r_drained[i_cur] <= 1'b1;
    end
  end

  // The RAM has one cycle of latency, so on a load cycle the address must
  // already point at the following word. Once ptr reaches PIX the last
  // address of the plane is held instead of running into the next channel.
  always_comb begin
    w_offset = int'(r_ptr[i_cur]) + (i_lookAhead ? 1 : 0);
    if (w_offset > PIX - 1) w_offset = PIX - 1;
    w_address = BASE_ADDR + int'(i_cur) * PIX + w_offset;
  end

  assign o_rdAddress = ADDR_WIDTH'(w_address);
  assign o_curLoaded = r_loaded[i_cur];
  assign o_curAtEnd  = (r_ptr[i_cur] == PTR_W'(PIX));
  assign o_drained   = r_drained;

endmodule

// File: rtl/input_channel_sequencer.sv
// ---------------------------------------------------------------------------
// input_channel_sequencer
// Streams a channel-planar image from the input RAM into conv core 0, one
// channel at a time, switching channel whenever the core holds the active
// lane. Per-channel progress and pending words survive switches.
// Ports:
//   clock_i, reset_i : clock, synchronous active-high reset
//   enable_i         : start request, sampled only in IDLE
//   ram_data_i       : RAM q, valid one cycle after ram_rdaddress_o
//   ram_rdaddress_o  : RAM read address (combinational)
//   hold_data_i      : per-lane back-pressure / channel-switch request
//   data_o           : per-lane pending word, lane c at [c*DATA_WIDTH +: DATA_WIDTH]
//   data_valid_o     : per-lane valid, at most one high
//   beat_count_o     : per-lane beat counters (only with INPUT_SEQ_STATS_EN)
//   done_o           : all channels transferred, sticky until reset
// Optional feature macro: INPUT_SEQ_STATS_EN
// ---------------------------------------------------------------------------
module input_channel_sequencer
  import input_sequencer_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int N_ROWS     = 28,
  parameter int N_COLS     = 28,
  parameter int N_CHANNELS = 3,
  parameter int BASE_ADDR  = 0
) (
  input  logic                             clock_i,
  input  logic                             reset_i,
  input  logic                             enable_i,
  input  logic [DATA_WIDTH-1:0]            ram_data_i,
  output logic [ADDR_WIDTH-1:0]            ram_rdaddress_o,
  input  logic [N_CHANNELS-1:0]            hold_data_i,
  output logic [N_CHANNELS*DATA_WIDTH-1:0] data_o,
  output logic [N_CHANNELS-1:0]            data_valid_o,
`ifdef INPUT_SEQ_STATS_EN
  output logic [N_CHANNELS*($clog2(N_ROWS*N_COLS)+1)-1:0] beat_count_o,
`endif
  output logic                             done_o
);

  localparam int PIX   = pix_count(N_ROWS, N_COLS);
  localparam int PTR_W = $clog2(PIX + 1);
  localparam int CUR_W = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;

  seq_state_t r_state, w_nextState;

  logic [DATA_WIDTH-1:0]   r_data [N_CHANNELS];
  logic [N_CHANNELS-1:0]   r_valid;
  logic [CUR_W-1:0]        r_cur;
  logic                    r_done;

  logic                    w_curLoaded, w_curAtEnd, w_curHold;
  logic [N_CHANNELS-1:0]   w_drained;
  logic [MAX_CHANNELS-1:0] w_drainedExt, w_drainedAfterExt;
  logic [CUR_W-1:0]        w_holdNext, w_drainNext;
  logic                    w_allDrained;
  logic                    w_primeLoaded, w_fill, w_streamLoad, w_finalBeat, w_holdSwitch;

  assign w_curHold = hold_data_i[r_cur];

  channel_pointer_bank #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .N_CHANNELS(N_CHANNELS),
    .PIX       (PIX),
    .BASE_ADDR (BASE_ADDR),
    .PTR_W     (PTR_W),
    .CUR_W     (CUR_W)
  ) u_bank (
    .i_clock     (clock_i),
    .i_reset     (reset_i),
    .i_cur       (r_cur),
    .i_advance   (w_fill | w_streamLoad),
    .i_setLoaded (w_fill),
    .i_setDrained(w_finalBeat),
    .i_lookAhead (w_fill | w_streamLoad),
    .o_curLoaded (w_curLoaded),
    .o_curAtEnd  (w_curAtEnd),
    .o_drained   (w_drained),
    .o_rdAddress (ram_rdaddress_o)
  );

  // Candidate next channels: on a hold the current channel is still live,
  // on a final beat it counts as drained already.
  always_comb begin
    w_drainedExt                 = '0;
    w_drainedExt[N_CHANNELS-1:0] = w_drained;
    w_drainedAfterExt            = w_drainedExt | (MAX_CHANNELS'(1) << r_cur);
    w_holdNext   = CUR_W'(next_channel(int'(r_cur), w_drainedExt, N_CHANNELS));
    w_drainNext  = CUR_W'(next_channel(int'(r_cur), w_drainedAfterExt, N_CHANNELS));
    w_allDrained = &w_drainedAfterExt[N_CHANNELS-1:0];
  end

  // FSM state register.
  always_ff @(posedge clock_i) begin
    if (reset_i) r_state <= IDLE;
    else         r_state <= w_nextState;
  end

  // FSM next-state logic; in STREAM a hold takes priority over a final beat.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:         if (enable_i) w_nextState = PRIME;
      PRIME:        w_nextState = w_curLoaded ? STREAM : FILL;
      FILL:         w_nextState = STREAM;
      STREAM: begin
        if (w_curHold)       w_nextState = WAIT_RELEASE;
        else if (w_curAtEnd) w_nextState = w_allDrained ? DONE : PRIME;
      end
      WAIT_RELEASE: if (!w_curHold) w_nextState = PRIME;
      DONE:         w_nextState = DONE;
      default:      w_nextState = IDLE;
    endcase
  end

  // FSM control outputs driving the lanes and the pointer bank.
  always_comb begin
    w_primeLoaded = 1'b0;
    w_fill        = 1'b0;
    w_streamLoad  = 1'b0;
    w_finalBeat   = 1'b0;
    w_holdSwitch  = 1'b0;
    case (r_state)
      PRIME: w_primeLoaded = w_curLoaded;
      FILL:  w_fill = 1'b1;
      STREAM: begin
        if (w_curHold)       w_holdSwitch = 1'b1;
        else if (w_curAtEnd) w_finalBeat  = 1'b1;
        else                 w_streamLoad = 1'b1;
      end
      default: ;
    endcase
  end

  // Data lanes, valids, active channel and done flag.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      for (int c = 0; c < N_CHANNELS; c++) r_data[c] <= '0;
      r_valid <= '0;
      r_cur   <= '0;
      r_done  <= 1'b0;
    end else begin
      if (w_fill || w_streamLoad)   r_data[r_cur]  <= ram_data_i;
      if (w_fill || w_primeLoaded)  r_valid[r_cur] <= 1'b1;
      if (w_holdSwitch || w_finalBeat) r_valid[r_cur] <= 1'b0;
      if (w_holdSwitch)             r_cur <= w_holdNext;
      if (w_finalBeat && !w_allDrained) r_cur <= w_drainNext;
      if (w_finalBeat && w_allDrained)  r_done <= 1'b1;
    end
  end

  for (genvar g = 0; g < N_CHANNELS; g++) begin : g_lane
    assign data_o[g*DATA_WIDTH +: DATA_WIDTH] = r_data[g];
  end

  assign data_valid_o = r_valid;
  assign done_o       = r_done;

`ifdef INPUT_SEQ_STATS_EN
  localparam int CNT_W = $clog2(PIX) + 1;
  logic [CNT_W-1:0] r_beatCount [N_CHANNELS];

  // A beat on any lane is valid without hold, independent of FSM state.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      for (int c = 0; c < N_CHANNELS; c++) r_beatCount[c] <= '0;
    end else begin
      for (int c = 0; c < N_CHANNELS; c++)
        if (r_valid[c] && !hold_data_i[c]) r_beatCount[c] <= r_beatCount[c] + CNT_W'(1);
    end
  end

  for (genvar g = 0; g < N_CHANNELS; g++) begin : g_stat
    assign beat_count_o[g*CNT_W +: CNT_W] = r_beatCount[g];
  end
`endif

endmodule

// File: tb/tb_input_channel_sequencer.sv
// ---------------------------------------------------------------------------
// tb_input_channel_sequencer
// Scoreboard bench: expected beats (lane, word, cycle gap) are queued as each
// scenario is set up and popped whenever the DUT transfers a word.
// RAM model returns its address as data, one cycle late.
// ---------------------------------------------------------------------------
module tb_input_channel_sequencer;

  localparam int N_CH  = 3;
  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int PIX   = 16;
  localparam int DW    = 32;
  localparam int AW    = 16;
  localparam int CNT_W = 5;

  logic              clock = 1'b0;
  logic              reset_i = 1'b1;
  logic              enable_i = 1'b0;
  logic [DW-1:0]     ramQ;
  logic [AW-1:0]     ramAddr;
  logic [N_CH-1:0]   hold_data_i = '0;
  logic [N_CH*DW-1:0] data_o;
  logic [N_CH-1:0]   data_valid_o;
  logic              done_o;
`ifdef INPUT_SEQ_STATS_EN
  logic [N_CH*CNT_W-1:0] beat_count_o;
`endif

  int checks = 0;
  int failures = 0;
  int cycle = 0;
  int lastBeat = 0;
  logic monitorOn = 1'b0;
  logic multiValid = 1'b0;

  typedef struct {
    int lane;
    int data;
    int gap;
  } expBeat_t;
  expBeat_t expQ[$];

  // Hold policy per lane: raise hold when the trigger word is presented,
  // drop it once the release lane shows valid. Fires once per scenario.
  logic trigEn [N_CH];
  int   trigData [N_CH];
  int   relLane [N_CH];
  int   holdState [N_CH];

  always #5 clock = ~clock;

  // Single-port RAM model with q = address.
  always_ff @(posedge clock) ramQ <= DW'(ramAddr);

  input_channel_sequencer #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .N_ROWS    (ROWS),
    .N_COLS    (COLS),
    .N_CHANNELS(N_CH),
    .BASE_ADDR (0)
  ) dut (
    .clock_i        (clock),
    .reset_i        (reset_i),
    .enable_i       (enable_i),
    .ram_data_i     (ramQ),
    .ram_rdaddress_o(ramAddr),
    .hold_data_i    (hold_data_i),
    .data_o         (data_o),
    .data_valid_o   (data_valid_o),
`ifdef INPUT_SEQ_STATS_EN
    .beat_count_o   (beat_count_o),
`endif
    .done_o         (done_o)
  );

  task automatic checkOutput(input string tag, input longint observed, input longint expected);
    checks++;
    if (observed != expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, observed, expected, cycle);
    end
  endtask

  function automatic logic [DW-1:0] laneData(input int c);
    return data_o[c*DW +: DW];
  endfunction

  task automatic pushRange(input int lane, input int first, input int last, input int firstGap);
    expBeat_t e;
    for (int v = first; v <= last; v++) begin
      e.lane = lane;
      e.data = v;
      e.gap  = (v == first) ? firstGap : 1;
      expQ.push_back(e);
    end
  endtask

  task automatic setTrigger(input int lane, input int word, input int rel);
    trigEn[lane]   = 1'b1;
    trigData[lane] = word;
    relLane[lane]  = rel;
  endtask

  // One cycle: drive inputs at the falling edge, then score any beat that
  // the coming rising edge will complete.
  task automatic applyStimulus(input logic en);
    logic [N_CH-1:0] holdVec;
    expBeat_t e;
    @(negedge clock);
    cycle++;
    enable_i = en;
    for (int c = 0; c < N_CH; c++) begin
      if (trigEn[c] && holdState[c] == 0 && data_valid_o[c] && int'(laneData(c)) == trigData[c])
        holdState[c] = 1;
      else if (holdState[c] == 1 && data_valid_o[relLane[c]])
        holdState[c] = 2;
      holdVec[c] = (holdState[c] == 1);
    end
    hold_data_i = holdVec;
    if ($countones(data_valid_o) > 1) multiValid = 1'b1;
    for (int c = 0; c < N_CH; c++) begin
      if (data_valid_o[c] && int'(laneData(c)) == c*PIX + PIX - 1)
        checkOutput("addr_clamp", longint'(ramAddr), c*PIX + PIX - 1);
      if (monitorOn && data_valid_o[c] && !holdVec[c]) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_beat_lane", c, -1);
        end else begin
          e = expQ.pop_front();
          checkOutput("beat_lane", c, e.lane);
          checkOutput("beat_data", longint'(laneData(c)), e.data);
          if (e.gap > 0) checkOutput("beat_gap", cycle - lastBeat, e.gap);
          lastBeat = cycle;
        end
      end
    end
  endtask

  task automatic runUntilEmpty(input int budget);
    int n = 0;
    while (expQ.size() > 0 && n < budget) begin
      applyStimulus(1'b0);
      n++;
    end
    checkOutput("queue_drained", expQ.size(), 0);
  endtask

  task automatic doReset();
    monitorOn = 1'b0;
    expQ.delete();
    for (int c = 0; c < N_CH; c++) begin
      trigEn[c] = 1'b0;
      holdState[c] = 0;
      trigData[c] = 0;
      relLane[c] = 0;
    end
    @(negedge clock);
    reset_i = 1'b1;
    enable_i = 1'b0;
    hold_data_i = '0;
    @(negedge clock);
    @(negedge clock);
    reset_i = 1'b0;
    monitorOn = 1'b1;
  endtask

  task automatic startRun();
    applyStimulus(1'b1);
    lastBeat = cycle;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // Reset state and idle behaviour.
    doReset();
    checkOutput("rst_valid", data_valid_o, 0);
    checkOutput("rst_data_bits", $countones(data_o), 0);
    checkOutput("rst_done", done_o, 0);
    checkOutput("rst_addr", ramAddr, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0);
    checkOutput("idle_addr", ramAddr, 0);
    checkOutput("idle_valid", data_valid_o, 0);

    // Full run without hold: latency 3, 3-cycle gap at each channel switch.
    $display("[TB] scenario: full run");
    startRun();
    pushRange(0, 0, 15, 3);
    pushRange(1, 16, 31, 3);
    pushRange(2, 32, 47, 3);
    runUntilEmpty(300);
    applyStimulus(1'b0);
    checkOutput("full_done", done_o, 1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1);
    checkOutput("done_sticky", done_o, 1);
    checkOutput("done_valid", data_valid_o, 0);
`ifdef INPUT_SEQ_STATS_EN
    for (int c = 0; c < N_CH; c++)
      checkOutput("beat_count", beat_count_o[c*CNT_W +: CNT_W], PIX);
`endif

    // Hold rotation: 0 -> 1 -> 2 -> back to 0, pending words re-presented.
    $display("[TB] scenario: hold rotation");
    doReset();
    setTrigger(0, 5, 1);
    setTrigger(1, 20, 2);
    setTrigger(2, 32, 0);
    startRun();
    pushRange(0, 0, 4, 3);
    pushRange(1, 16, 19, 5);
    pushRange(0, 5, 15, 8);
    pushRange(1, 20, 31, 2);
    pushRange(2, 32, 47, 2);
    runUntilEmpty(400);
    applyStimulus(1'b0);
    checkOutput("hold_done", done_o, 1);

    // Hold together with the final word of lane 0: word 15 delivered once later.
    $display("[TB] scenario: hold on final word");
    doReset();
    setTrigger(0, 15, 1);
    startRun();
    pushRange(0, 0, 14, 3);
    pushRange(1, 16, 31, 5);
    pushRange(2, 32, 47, 3);
    pushRange(0, 15, 15, 2);
    runUntilEmpty(400);
    applyStimulus(1'b0);
    checkOutput("final_hold_done", done_o, 1);
    checkOutput("final_hold_valid", data_valid_o, 0);

    // Reset pulse mid-stream on lane 1, then restart from scratch.
    $display("[TB] scenario: reset mid-stream");
    doReset();
    startRun();
    pushRange(0, 0, 15, 3);
    pushRange(1, 16, 19, 3);
    runUntilEmpty(300);
    monitorOn = 1'b0;
    @(negedge clock);
    reset_i = 1'b1;
    hold_data_i = '0;
    @(negedge clock);
    checkOutput("midrst_valid", data_valid_o, 0);
    checkOutput("midrst_data_bits", $countones(data_o), 0);
    checkOutput("midrst_addr", ramAddr, 0);
    checkOutput("midrst_done", done_o, 0);
    reset_i = 1'b0;
    monitorOn = 1'b1;
    startRun();
    pushRange(0, 0, 15, 3);
    runUntilEmpty(300);

    checkOutput("one_hot_valid", multiValid, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
